// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM wrapper: deserialises {cmd, payload} words on
// MOSI and serialises RAM read data back on MISO, with abort and read-timeout detection.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              rd_pending,
  output logic              busy,
  output logic              frame_err
);

  localparam int RX_W    = DATA_W + 2;
  localparam int CNT_MAX = (DATA_W + 3 > TX_TIMEOUT + 1) ? DATA_W + 3 : TX_TIMEOUT + 1;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RX_W-1:0]   sr_q, sr_d;
  logic [RX_W-1:0]   shift_in;
  logic [RX_W-1:0]   rx_data_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              miso_d, rx_valid_d, rd_pending_d, frame_err_d;
  logic              abort;

  assign busy = (state_q != IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    tx_d         = tx_q;
    cnt_d        = cnt_q;
    rx_data_d    = rx_data;
    rd_pending_d = rd_pending;
    miso_d       = 1'b0;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;

    if (MSB_FIRST) shift_in = {sr_q[RX_W-2:0], MOSI};
    else           shift_in = {MOSI, sr_q[RX_W-1:1]};

    // SS_n rising mid-frame drops the partial word; rd_pending is left as is so a read can retry.
    abort = SS_n && (state_q != IDLE) && (state_q != DONE);

    if (abort) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (!SS_n) state_d = CHK_CMD;

        CHK_CMD: begin
          cnt_d = CNT_W'(RX_W);
          if (!MOSI)           state_d = WRITE;
          else if (!rd_pending) state_d = READ_ADD;
          else                  state_d = READ_DATA;
        end

        WRITE, READ_ADD, READ_DATA: begin
          sr_d  = shift_in;
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
          if (cnt_q == CNT_W'(1)) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            if (state_q == READ_DATA) begin
              state_d = RD_WAIT;
            end else begin
              state_d = DONE;
              if (state_q == READ_ADD) rd_pending_d = 1'b1;
            end
          end
        end

        RD_WAIT: begin
          if (tx_valid) begin
            tx_d    = tx_data;
            cnt_d   = CNT_W'(DATA_W);
            state_d = RD_SHIFT;
          end else if (TX_TIMEOUT != 0 && int'(cnt_q) + 1 >= TX_TIMEOUT) begin
            frame_err_d = 1'b1;
            state_d     = DONE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        RD_SHIFT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (MSB_FIRST) begin
              miso_d = tx_q[DATA_W-1];
              tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end else begin
              miso_d = tx_q[0];
              tx_d   = {1'b0, tx_q[DATA_W-1:1]};
            end
          end else begin
            rd_pending_d = 1'b0;
            state_d      = DONE;
          end
        end

        DONE: if (SS_n) state_d = IDLE;

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the few data registers are reset along with control; they are flops, not a RAM array.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      tx_q       <= '0;
      cnt_q      <= '0;
      MISO       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rd_pending <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      tx_q       <= tx_d;
      cnt_q      <= cnt_d;
      MISO       <= miso_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      rd_pending <= rd_pending_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: directed and randomised SPI frames checked against a
// transaction-level model of the slave (expected words, MISO bit streams, pending-read flag).
module tb_spi_slave_param;

  localparam int DATA_W     = 8;
  localparam bit MSB_FIRST  = 1'b1;
  localparam int TX_TIMEOUT = 16;
  localparam int RX_W       = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst_n, SS_n, MOSI, tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              MISO, rx_valid, rd_pending, busy, frame_err;
  logic [RX_W-1:0]   rx_data;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [RX_W-1:0] m_rx_data;
  bit              m_rd_pending;

  spi_slave_param #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .tx_valid(tx_valid),
    .tx_data(tx_data), .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_pending(rd_pending), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ss, input bit mosi, input bit tv, input logic [DATA_W-1:0] td);
    SS_n = ss; MOSI = mosi; tx_valid = tv; tx_data = td;
    @(posedge clk); #1;
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [DATA_W-1:0] rnd_byte();
    return DATA_W'($urandom);
  endfunction

  // Bit i (0 = first on the wire) of a word of width w.
  function automatic bit wire_bit(input logic [31:0] v, input int w, input int i);
    return MSB_FIRST ? v[w-1-i] : v[i];
  endfunction

  // Select + dispatch + RX_W word bits. abort_at < RX_W raises SS_n on the edge sampling that bit.
  task automatic rx_frame(input bit disp, input logic [RX_W-1:0] word, input int abort_at,
                          output bit ok);
    bit to_addr;
    ok = 1'b0;
    to_addr = disp && !m_rd_pending;
    step(1'b0, rnd(), rnd(), rnd_byte());
    check("sel_busy", busy, 1);
    step(1'b0, disp, rnd(), rnd_byte());
    check("cmd_rx_valid", rx_valid, 0);
    for (int i = 0; i < RX_W; i++) begin
      if (i == abort_at) begin
        step(1'b1, wire_bit(word, RX_W, i), rnd(), rnd_byte());
        check("abort_ferr", frame_err, 1);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_rx_data", rx_data, m_rx_data);
        check("abort_busy", busy, 0);
        check("abort_rd_pending", rd_pending, m_rd_pending);
        step(1'b1, 1'b0, 1'b0, '0);
        check("abort_ferr_clear", frame_err, 0);
        return;
      end
      step(1'b0, wire_bit(word, RX_W, i), rnd(), rnd_byte());
      if (i < RX_W - 1) begin
        check("shift_rx_valid", rx_valid, 0);
        check("shift_rx_data", rx_data, m_rx_data);
      end else begin
        m_rx_data = word;
        if (to_addr) m_rd_pending = 1'b1;
        check("word_rx_valid", rx_valid, 1);
        check("word_rx_data", rx_data, m_rx_data);
      end
      check("shift_rd_pending", rd_pending, m_rd_pending);
    end
    ok = 1'b1;
  endtask

  // DONE: MOSI ignored until SS_n high.
  task automatic close_frame();
    step(1'b0, rnd(), rnd(), rnd_byte());
    check("done_rx_valid", rx_valid, 0);
    check("done_busy", busy, 1);
    check("done_miso", MISO, 0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("idle_busy", busy, 0);
  endtask

  task automatic wr_frame(input logic [RX_W-1:0] word);
    bit ok;
    rx_frame(1'b0, word, RX_W, ok);
    if (ok) close_frame();
  endtask

  task automatic rd_addr_frame(input logic [RX_W-1:0] word);
    bit ok;
    rx_frame(1'b1, word, RX_W, ok);
    check("addr_rd_pending", rd_pending, 1);
    if (ok) close_frame();
  endtask

  // RD_WAIT for 'delay' idle cycles, then tx_valid with d; abort_at < DATA_W aborts mid-shift.
  task automatic rd_return(input int delay, input logic [DATA_W-1:0] d, input int abort_at);
    for (int k = 0; k < delay; k++) begin
      step(1'b0, rnd(), 1'b0, rnd_byte());
      check("wait_ferr", frame_err, 0);
      check("wait_miso", MISO, 0);
    end
    step(1'b0, rnd(), 1'b1, d);
    check("cap_miso", MISO, 0);
    check("cap_busy", busy, 1);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == abort_at) begin
        step(1'b1, 1'b0, rnd(), rnd_byte());
        check("rs_abort_ferr", frame_err, 1);
        check("rs_abort_miso", MISO, 0);
        check("rs_abort_rd_pending", rd_pending, 1);
        check("rs_abort_busy", busy, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("rs_abort_ferr_clear", frame_err, 0);
        return;
      end
      step(1'b0, rnd(), rnd(), rnd_byte());
      check("miso_bit", MISO, wire_bit(d, DATA_W, i));
      check("shift_pending", rd_pending, 1);
      check("shift_ferr", frame_err, 0);
    end
    step(1'b0, rnd(), rnd(), rnd_byte());
    m_rd_pending = 1'b0;
    check("end_miso", MISO, 0);
    check("end_rd_pending", rd_pending, 0);
    check("end_busy", busy, 1);
    step(1'b1, 1'b0, 1'b0, '0);
    check("end_idle", busy, 0);
  endtask

  task automatic rd_data_frame(input logic [RX_W-1:0] word, input int delay,
                               input logic [DATA_W-1:0] d, input int abort_at);
    bit ok;
    rx_frame(1'b1, word, RX_W, ok);
    if (ok) rd_return(delay, d, abort_at);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    m_rx_data = '0; m_rd_pending = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rst_miso", MISO, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rd_pending", rd_pending, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0);
    check("idle_after_rst", busy, 0);

    // Writes: directed vector then random words
    wr_frame(10'h0A5);
    repeat (4) wr_frame(RX_W'($urandom));

    // Read address then read data (tx_valid on the third RD_WAIT cycle)
    rd_addr_frame(10'h207);
    rd_data_frame({2'b11, rnd_byte()}, 2, 8'hC3, DATA_W);

    // Random read pairs with random return latency
    repeat (4) begin
      rd_addr_frame(RX_W'($urandom));
      rd_data_frame(RX_W'($urandom), int'($urandom_range(0, TX_TIMEOUT - 1)), rnd_byte(), DATA_W);
    end

    // tx_valid on the last cycle before timeout still wins
    rd_addr_frame(RX_W'($urandom));
    rd_data_frame(RX_W'($urandom), TX_TIMEOUT - 1, rnd_byte(), DATA_W);

    // Aborts during a write: after 5 payload bits, and on the last bit
    rx_frame(1'b0, RX_W'($urandom), 5, ok);
    check("abort_result", ok, 0);
    rx_frame(1'b0, RX_W'($urandom), RX_W - 1, ok);
    wr_frame(RX_W'($urandom));

    // Timeout: tx_valid never arrives
    rd_addr_frame(RX_W'($urandom));
    rx_frame(1'b1, RX_W'($urandom), RX_W, ok);
    for (int k = 1; k < TX_TIMEOUT; k++) begin
      step(1'b0, rnd(), 1'b0, rnd_byte());
      check("to_wait_ferr", frame_err, 0);
    end
    step(1'b0, rnd(), 1'b0, rnd_byte());
    check("to_ferr", frame_err, 1);
    check("to_miso", MISO, 0);
    check("to_rd_pending", rd_pending, 1);
    check("to_busy", busy, 1);
    close_frame();
    check("to_ferr_clear", frame_err, 0);

    // Abort mid-RD_SHIFT, then the retried read completes
    rd_data_frame(RX_W'($urandom), 1, rnd_byte(), 3);
    rd_data_frame(RX_W'($urandom), 0, rnd_byte(), DATA_W);

    // Reset in the middle of RD_SHIFT
    rd_addr_frame(RX_W'($urandom));
    rx_frame(1'b1, RX_W'($urandom), RX_W, ok);
    step(1'b0, 1'b0, 1'b1, 8'hA6);
    repeat (3) step(1'b0, rnd(), 1'b0, rnd_byte());
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0);
    m_rx_data = '0; m_rd_pending = 1'b0;
    check("mrst_miso", MISO, 0);
    check("mrst_rx_data", rx_data, 0);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_rd_pending", rd_pending, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ferr", frame_err, 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0);
    check("mrst_ferr_after", frame_err, 0);
    wr_frame(RX_W'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
